// File: rtl/axi2apb_pkg.sv
// Shared types and constants for the AXI-to-APB bridge.
//   state_e        : bridge FSM states
//   RESP_*         : AXI response codes
//   BURST_*        : AXI burst type codes
//   burst_bad()    : true when a burst cannot be mapped onto APB beats
package axi2apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_DATA,
        SETUP,
        ACCESS,
        B_RESP,
        R_DATA
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int APB_DATA_WIDTH = 32;

    // Only FIXED/INCR with beats no wider than the 32-bit APB bus are mapped.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
        return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size > 3'd2);
    endfunction

endpackage

// File: rtl/axi2apb_bridge_addr_gen.sv
// Per-burst beat sequencer.
//   load_i   : capture a new burst (addr/len/size/burst)
//   step_i   : current beat finished, advance to the next
//   addr_o   : address of the current beat
//   last_o   : current beat is the final one
//   bad_o    : captured burst is unsupported
module axi2apb_addr_gen
    import axi2apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              bad_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic              bad_q;

    // INCR advances by the beat size; the carry simply wraps at the top of the space.
    assign addr_d = (burst_q == BURST_INCR) ? addr_q + (ADDR_W'(1) << size_q) : addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            bad_q   <= 1'b0;
        end else if (load_i) begin
            addr_q  <= addr_i;
            cnt_q   <= len_i;
            size_q  <= size_i;
            burst_q <= burst_i;
            bad_q   <= burst_bad(burst_i, size_i);
        end else if (step_i) begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_q - LEN_W'(1);
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == '0);
    assign bad_o  = bad_q;

endmodule

// File: rtl/axi2apb_bridge.sv
// AXI slave to APB master bridge. One burst in flight; each AXI beat becomes
// one APB transfer. Unsupported bursts are answered with SLVERR without any
// APB activity. Read/write contention is arbitrated round-robin.
//   AXI_AW*/W*/B* : AXI write channels (slave side)
//   AXI_AR*/R*    : AXI read channels (slave side)
//   APB_*         : APB master
module axi2apb_bridge
    import axi2apb_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 64,
    parameter int C_AXI_LEN_WIDTH  = 4
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_ARESET,
    input  logic [C_AXI_ID_WIDTH-1:0]     AXI_AWID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
    input  logic [C_AXI_LEN_WIDTH-1:0]    AXI_AWLEN,
    input  logic [2:0]                    AXI_AWSIZE,
    input  logic [1:0]                    AXI_AWBURST,
    input  logic [2:0]                    AXI_AWPROT,
    input  logic                          AXI_AWVALID,
    output logic                          AXI_AWREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]     AXI_WID,
    input  logic [C_AXI_DATA_WIDTH-1:0]   AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
    input  logic                          AXI_WLAST,
    input  logic                          AXI_WVALID,
    output logic                          AXI_WREADY,
    output logic [C_AXI_ID_WIDTH-1:0]     AXI_BID,
    output logic [1:0]                    AXI_BRESP,
    output logic                          AXI_BVALID,
    input  logic                          AXI_BREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]     AXI_ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
    input  logic [C_AXI_LEN_WIDTH-1:0]    AXI_ARLEN,
    input  logic [2:0]                    AXI_ARSIZE,
    input  logic [1:0]                    AXI_ARBURST,
    input  logic [2:0]                    AXI_ARPROT,
    input  logic                          AXI_ARVALID,
    output logic                          AXI_ARREADY,
    output logic [C_AXI_ID_WIDTH-1:0]     AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0]   AXI_RDATA,
    output logic [1:0]                    AXI_RRESP,
    output logic                          AXI_RLAST,
    output logic                          AXI_RVALID,
    input  logic                          AXI_RREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   APB_PADDR,
    output logic                          APB_PSEL,
    output logic                          APB_PENABLE,
    output logic                          APB_PWRITE,
    output logic [APB_DATA_WIDTH-1:0]     APB_PWDATA,
    output logic [APB_DATA_WIDTH/8-1:0]   APB_PSTRB,
    output logic [2:0]                    APB_PPROT,
    input  logic [APB_DATA_WIDTH-1:0]     APB_PRDATA,
    input  logic                          APB_PREADY,
    input  logic                          APB_PSLVERR
);

    state_e                        state_q;
    logic                          rr_q;      // 1: write side wins a tie
    logic                          is_wr_q;
    logic                          err_q;     // accumulated write error
    logic [C_AXI_ID_WIDTH-1:0]     id_q;
    logic [2:0]                    prot_q;
    logic [APB_DATA_WIDTH-1:0]     pwdata_q;
    logic [APB_DATA_WIDTH/8-1:0]   pstrb_q;
    logic [APB_DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                    rresp_q;

    logic                          grant_w, aw_hs, ar_hs, apb_done, r_hs, step;
    logic [C_AXI_ADDR_WIDTH-1:0]   beat_addr;
    logic                          beat_last, bad;

    // WID is not needed: only one burst is ever outstanding.
    logic unused_wid;
    assign unused_wid = ^AXI_WID;

    assign grant_w  = AXI_AWVALID && (rr_q || !AXI_ARVALID);
    assign aw_hs    = (state_q == IDLE) && grant_w;
    assign ar_hs    = (state_q == IDLE) && AXI_ARVALID && !grant_w;
    assign apb_done = (state_q == ACCESS) && APB_PREADY;
    assign r_hs     = (state_q == R_DATA) && AXI_RREADY;
    // A beat retires at the end of its APB write, its R handshake, or (bad write) its W handshake.
    assign step     = (apb_done && is_wr_q) || r_hs ||
                      ((state_q == W_DATA) && AXI_WVALID && bad);

    axi2apb_addr_gen #(
        .ADDR_W (C_AXI_ADDR_WIDTH),
        .LEN_W  (C_AXI_LEN_WIDTH)
    ) u_addr_gen (
        .clk_i   (AXI_ACLK),
        .rst_i   (AXI_ARESET),
        .load_i  (aw_hs || ar_hs),
        .addr_i  (aw_hs ? AXI_AWADDR  : AXI_ARADDR),
        .len_i   (aw_hs ? AXI_AWLEN   : AXI_ARLEN),
        .size_i  (aw_hs ? AXI_AWSIZE  : AXI_ARSIZE),
        .burst_i (aw_hs ? AXI_AWBURST : AXI_ARBURST),
        .step_i  (step),
        .addr_o  (beat_addr),
        .last_o  (beat_last),
        .bad_o   (bad)
    );

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state_q  <= IDLE;
            rr_q     <= 1'b1;
            is_wr_q  <= 1'b0;
            err_q    <= 1'b0;
            id_q     <= '0;
            prot_q   <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_hs) begin
                        state_q <= W_DATA;
                        rr_q    <= 1'b0;
                        is_wr_q <= 1'b1;
                        err_q   <= 1'b0;
                        id_q    <= AXI_AWID;
                        prot_q  <= AXI_AWPROT;
                    end else if (ar_hs) begin
                        rr_q    <= 1'b1;
                        is_wr_q <= 1'b0;
                        err_q   <= 1'b0;
                        id_q    <= AXI_ARID;
                        prot_q  <= AXI_ARPROT;
                        // Bad reads skip APB and return zero data with SLVERR on every beat.
                        if (burst_bad(AXI_ARBURST, AXI_ARSIZE)) begin
                            state_q <= R_DATA;
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end else begin
                            state_q <= SETUP;
                        end
                    end
                end
                W_DATA: begin
                    if (AXI_WVALID) begin
                        pwdata_q <= beat_addr[2] ? AXI_WDATA[63:32] : AXI_WDATA[31:0];
                        pstrb_q  <= beat_addr[2] ? AXI_WSTRB[7:4]   : AXI_WSTRB[3:0];
                        if (AXI_WLAST != beat_last) err_q <= 1'b1;
                        if (!bad)           state_q <= SETUP;
                        else if (beat_last) state_q <= B_RESP;
                    end
                end
                SETUP: state_q <= ACCESS;
                ACCESS: begin
                    if (APB_PREADY) begin
                        if (is_wr_q) begin
                            if (APB_PSLVERR) err_q <= 1'b1;
                            state_q <= beat_last ? B_RESP : W_DATA;
                        end else begin
                            rdata_q <= APB_PRDATA;
                            rresp_q <= APB_PSLVERR ? RESP_SLVERR : RESP_OKAY;
                            state_q <= R_DATA;
                        end
                    end
                end
                B_RESP: if (AXI_BREADY) state_q <= IDLE;
                R_DATA: begin
                    if (AXI_RREADY) begin
                        if (beat_last) state_q <= IDLE;
                        else if (!bad) state_q <= SETUP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign AXI_AWREADY = aw_hs;
    assign AXI_ARREADY = ar_hs;
    assign AXI_WREADY  = (state_q == W_DATA);
    assign AXI_BVALID  = (state_q == B_RESP);
    assign AXI_BID     = id_q;
    assign AXI_BRESP   = (AXI_BVALID && (err_q || bad)) ? RESP_SLVERR : RESP_OKAY;
    assign AXI_RVALID  = (state_q == R_DATA);
    assign AXI_RID     = id_q;
    assign AXI_RDATA   = {rdata_q, rdata_q};
    assign AXI_RRESP   = rresp_q;
    assign AXI_RLAST   = AXI_RVALID && beat_last;
    assign APB_PADDR   = beat_addr;
    assign APB_PSEL    = (state_q == SETUP) || (state_q == ACCESS);
    assign APB_PENABLE = (state_q == ACCESS);
    assign APB_PWRITE  = is_wr_q;
    assign APB_PWDATA  = pwdata_q;
    assign APB_PSTRB   = pstrb_q;
    assign APB_PPROT   = prot_q;

endmodule
